// File: rtl/gray_step_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the button-to-step controller.
package gray_step_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int LONG_CYC_DEF = 8;
  localparam int TICK_CYC_DEF = 4;

endpackage

// File: rtl/gray_tick_gen.sv
// Modulo-TICK_CYC prescaler; wrap pulses in the cycle the count sits at TICK_CYC-1.
module gray_tick_gen #(
  parameter int TICK_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int TW = $clog2(TICK_CYC);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYC - 1);

  logic [TW-1:0] presc;

  assign wrap = en && !clr && (presc == TICK_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      if (presc == TICK_MAX) presc <= '0;
      else                   presc <= presc + TW'(1);
    end
  end

endmodule

// File: rtl/gray_step_ctrl.sv
// Push-button sequencer for the Gray counter: short press steps once, long press latches auto-run.
// Optional GRAY_STEP_CTRL_DIR_EN toggles dir on every RUN->STOP so alternate runs count up/down.
module gray_step_ctrl
  import gray_step_ctrl_pkg::*;
#(
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int TICK_CYC = TICK_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn,
  output logic step,
  output logic running,
  output logic busy,
  output logic dir
);

  localparam int HW = $clog2(LONG_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC - 1);

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          btn_q;
  logic          tick_run;
  logic          tick_wrap;
  logic          stop_press;

  // Auto-run is stopped only by a fresh press, so the long press that started it is ignored.
  assign tick_run   = en && (state == RUN);
  assign stop_press = tick_run && btn && !btn_q;

  gray_tick_gen #(
    .TICK_CYC(TICK_CYC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (!tick_run),
    .en   (tick_run),
    .wrap (tick_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      step     <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      btn_q <= btn;
      step  <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            hold_cnt <= '0;
            if (btn) state <= PRESS;
          end
          PRESS: begin
            if (!btn) begin
              state    <= IDLE;
              step     <= 1'b1;
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_MAX) begin
              state    <= RUN;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          RUN: begin
            step <= tick_wrap;
            if (stop_press) state <= STOP;
          end
          STOP: begin
            if (!btn) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign running = (state == RUN);
  assign busy    = (state != IDLE);

`ifdef GRAY_STEP_CTRL_DIR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          dir <= 1'b0;
    else if (stop_press) dir <= ~dir;
  end
`else
  assign dir = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed bench for gray_step_ctrl: vector table plus run/stop, reset and enable sequences.
module tb_gray_step_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic btn;
  logic step;
  logic running;
  logic busy;
  logic dir;

  int checks   = 0;
  int failures = 0;
  logic exp_dir = 1'b0;

  typedef struct {
    logic btn;
    logic en;
    logic step;
    logic running;
    logic busy;
  } vec_t;

  vec_t vecs[14];

  gray_step_ctrl #(
    .LONG_CYC(8),
    .TICK_CYC(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .btn    (btn),
    .step   (step),
    .running(running),
    .busy   (busy),
    .dir    (dir)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: step/running/busy/dir got %b expected %b", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic s, input logic r, input logic b);
    check(name, {step, running, busy, dir}, {s, r, b, exp_dir});
  endtask

  task automatic note_stop();
`ifdef GRAY_STEP_CTRL_DIR_EN
    exp_dir = ~exp_dir;
`endif
  endtask

  // From IDLE, hold the button long enough to reach RUN, checking every cycle.
  task automatic long_press(input string tag);
    for (int i = 1; i <= 9; i++) begin
      btn = 1'b1;
      cyc();
      expect_out($sformatf("%s_press%0d", tag, i), 1'b0, (i == 9), 1'b1);
    end
  endtask

  initial begin
    vecs[0]  = '{btn: 1'b1, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b1};
    vecs[1]  = '{btn: 1'b1, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b1};
    vecs[2]  = '{btn: 1'b1, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b1};
    vecs[3]  = '{btn: 1'b0, en: 1'b1, step: 1'b1, running: 1'b0, busy: 1'b0};
    vecs[4]  = '{btn: 1'b0, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b0};
    vecs[5]  = '{btn: 1'b0, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b0};
    vecs[6]  = '{btn: 1'b1, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b1};
    vecs[7]  = '{btn: 1'b1, en: 1'b0, step: 1'b0, running: 1'b0, busy: 1'b0};
    vecs[8]  = '{btn: 1'b0, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b0};
    vecs[9]  = '{btn: 1'b1, en: 1'b0, step: 1'b0, running: 1'b0, busy: 1'b0};
    vecs[10] = '{btn: 1'b0, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b0};
    vecs[11] = '{btn: 1'b1, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b1};
    vecs[12] = '{btn: 1'b0, en: 1'b1, step: 1'b1, running: 1'b0, busy: 1'b0};
    vecs[13] = '{btn: 1'b0, en: 1'b1, step: 1'b0, running: 1'b0, busy: 1'b0};

    // Reset held, then idle with the button released.
    reset = 1'b0;
    en    = 1'b1;
    btn   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out($sformatf("reset_hold%0d", i), 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      expect_out($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Short presses and enable gating.
    for (int i = 0; i < 14; i++) begin
      btn = vecs[i].btn;
      en  = vecs[i].en;
      cyc();
      expect_out($sformatf("vec%0d", i), vecs[i].step, vecs[i].running, vecs[i].busy);
    end
    en = 1'b1;

    // Long press into RUN; button held 3 more cycles, then released; run keeps ticking.
    long_press("run1");
    for (int k = 1; k <= 20; k++) begin
      btn = (k <= 3);
      cyc();
      expect_out($sformatf("run1_k%0d", k), (k % 4 == 0), 1'b1, 1'b1);
    end

    // Stop press held 2 cycles, then released.
    btn = 1'b1;
    note_stop();
    cyc();
    expect_out("stop1_enter", 1'b0, 1'b0, 1'b1);
    cyc();
    expect_out("stop1_hold", 1'b0, 1'b0, 1'b1);
    btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      expect_out($sformatf("stop1_idle%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Second run; stop press lands exactly on a tick, which still strobes.
    long_press("run2");
    for (int k = 1; k <= 3; k++) begin
      btn = 1'b0;
      cyc();
      expect_out($sformatf("run2_k%0d", k), 1'b0, 1'b1, 1'b1);
    end
    btn = 1'b1;
    note_stop();
    cyc();
    expect_out("stop2_tick", 1'b1, 1'b0, 1'b1);
    cyc();
    expect_out("stop2_hold", 1'b0, 1'b0, 1'b1);
    btn = 1'b0;
    cyc();
    expect_out("stop2_idle", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between two ticks of a run.
    long_press("run3");
    for (int k = 1; k <= 6; k++) begin
      btn = 1'b0;
      cyc();
      expect_out($sformatf("run3_k%0d", k), (k == 4), 1'b1, 1'b1);
    end
    reset   = 1'b0;
    exp_dir = 1'b0;
    #2;
    expect_out("async_reset", 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    expect_out("reset_mid", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      expect_out($sformatf("post_reset%0d", i), 1'b0, 1'b0, 1'b0);
    end
    btn = 1'b1;
    cyc();
    expect_out("fresh_press", 1'b0, 1'b0, 1'b1);
    btn = 1'b0;
    cyc();
    expect_out("fresh_step", 1'b1, 1'b0, 1'b0);
    cyc();
    expect_out("fresh_after", 1'b0, 1'b0, 1'b0);

    // en=0 mid-PRESS at hold_cnt=5 restarts the hold from zero.
    for (int i = 1; i <= 6; i++) begin
      btn = 1'b1;
      cyc();
      expect_out($sformatf("pre_en%0d", i), 1'b0, 1'b0, 1'b1);
    end
    en = 1'b0;
    cyc();
    expect_out("en_low_press", 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    long_press("run4");

    // en=0 during RUN forces IDLE and holds dir.
    en = 1'b0;
    cyc();
    expect_out("en_low_run", 1'b0, 1'b0, 1'b0);
    en  = 1'b1;
    btn = 1'b0;
    cyc();
    expect_out("en_back", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
